nand3_stimulus_checker: RTL and testbench
=========================================

Name: nand3_stimulus_checker

Overview:
Clocked stimulus generator and response checker for the three-input NAND gate under test. It drives a, b and c through all 8 input combinations, holding each one for a programmable dwell. It samples the gate output d after each dwell and compares it against the expected NAND value, then reports a per-pattern error map, an error count and a pass/done summary. It sits directly upstream of the gate (feeding a/b/c) and consumes the gate's output d.

Parameters:
DWELL, 4, cycles each pattern is driven before sampling; legal range 1..255
CNT_W, 8, width of the internal dwell counter; must hold DWELL-1
ERR_W, 4, width of err_cnt; saturates at 2^ERR_W-1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled in IDLE or DONE only
d  input  1  output of the DUT gate, same clock domain
a  output  1  DUT input, MSB of pattern
b  output  1  DUT input, middle bit of pattern
c  output  1  DUT input, LSB of pattern
busy  output  1  high while in DRIVE or SAMPLE
done  output  1  high in DONE, held until the next start
pass  output  1  valid when done=1; 1 iff err_cnt==0
err_cnt  output  ERR_W  number of mismatching patterns
err_map  output  8  bit i set iff pattern {a,b,c}==i mismatched

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, pattern=0, dwell count=0.
  - a=b=c=0; busy=done=pass=0; err_cnt=0; err_map=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: {a,b,c}=000. start=1 at an edge causes the following:
  - pattern=0, dwell count=0, err_cnt=0, err_map=0
  - next state DRIVE.
- DRIVE:
  - {a,b,c}=pattern, with c as LSB.
  - The dwell counter increments each cycle.
  - When the counter equals DWELL-1, go to SAMPLE. DRIVE therefore lasts exactly DWELL cycles.
- SAMPLE (1 cycle):
  - {a,b,c} are still held at pattern.
  - Expected value = ~(a&b&c).
  - If d != expected: set err_map[pattern], and increment err_cnt (saturating).
  - If pattern==7, go to DONE. Otherwise increment pattern, clear the counter, and go to DRIVE.
- Pattern order: 000, 001, 010, ..., 111. Each pattern is held DWELL+1 cycles in total.
- DONE:
  - done=1, pass=(err_cnt==0), busy=0, {a,b,c}=000.
  - err_cnt and err_map are held stable.
  - start=1 behaves exactly as in IDLE: results are cleared and a new sweep begins.
- Latency: with start high at edge k, DRIVE begins at k+1. done rises after edge k+1+8*(DWELL+1). For DWELL=4 that is 40 cycles after entering DRIVE.
- start while busy=1 is ignored; the sweep is not restarted.
- Reset mid-sweep aborts immediately and asynchronously to the reset values above. The next sweep needs a fresh start.
- d is sampled only in SAMPLE; its value in any other state has no effect.
- The pass output is 0 whenever done=0.
- err_cnt saturation: with ERR_W>=4 no saturation occurs (maximum is 8). With smaller ERR_W, err_cnt clamps at its all-ones value.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3)
  - NUM_PATTERNS=8
  - LAST_PATTERN=3'd7
- One sub-module: dwell_timer.
  - Inputs: clk, rst_n, clear, enable.
  - Output: expire, high when count==DWELL-1.
  - Parameterised by DWELL and CNT_W.
- FSM, pattern register, comparator and error logging stay in the top module.

Test Plan:
1. DUT is a correct NAND, DWELL=4, pulse start -> {a,b,c} steps 000..111, each held 5 cycles; done rises 40 cycles after DRIVE entry; pass=1, err_cnt=0, err_map=8'h00.
2. d stuck at 1 -> only pattern 111 mismatches; err_map=8'h80, err_cnt=1, pass=0.
3. d stuck at 0 -> err_map=8'h7F, err_cnt=7, pass=0.
4. DUT replaced by a 3-input AND -> all patterns mismatch; err_map=8'hFF, err_cnt=8, pass=0.
5. Assert rst_n=0 while pattern=3 in DRIVE -> a=b=c=0, busy=0, err_cnt=0, err_map=0 immediately. Then start -> a full clean sweep completes as in test 1.
6. start pulsed during a sweep -> ignored, done still at cycle 40. Then start in DONE -> done drops the next cycle, results clear, and the second sweep reproduces the test 1 results; also run with DWELL=1 and check done at 16 cycles.

Source files
------------

// File: rtl/nand3_stimulus_checker_pkg.sv
// Shared definitions for the three-input NAND stimulus generator/checker.
//
// Contents:
//   state_t        - sweep controller states (IDLE, DRIVE, SAMPLE, DONE)
//   NUM_PATTERNS   - number of input combinations swept (2^3)
//   LAST_PATTERN   - final pattern of a sweep; sampling it ends the sweep
//   expected_nand  - golden response of the gate for a given {a,b,c}
package nand3_stimulus_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int         NUM_PATTERNS = 8;
    localparam logic [2:0] LAST_PATTERN = 3'd7;

    // The gate under test is a NAND: its output is low only when all three
    // inputs are high.
    function automatic logic expected_nand(input logic [2:0] pattern);
        return ~&pattern;
    endfunction

endpackage

// File: rtl/nand3_stimulus_checker_dwell_timer.sv
// Dwell timer for the NAND stimulus checker.
//
// Counts cycles while enabled and flags the last cycle of a dwell period.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   clear   in   synchronous clear of the count (dominates enable)
//   enable  in   advance the count by one this cycle
//   expire  out  high while the count equals DWELL-1
//
// Parameters:
//   DWELL   cycles per dwell period (1..255)
//   CNT_W   counter width; must be able to hold DWELL-1
module dwell_timer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    // Cycle counter. Clear wins over enable so the owner can hold the
    // counter at zero whenever it is not timing a dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Expire on the final cycle of the dwell so the owner can leave on the
    // same edge, making the dwell exactly DWELL cycles long. With DWELL=1
    // this is true on the very first cycle.
    assign expire = (count == CNT_W'(DWELL - 1));

endmodule

// File: rtl/nand3_stimulus_checker.sv
// Stimulus generator and response checker for a three-input NAND gate.
//
// On start, drives {a,b,c} through 000..111, holding each pattern for DWELL
// cycles followed by one SAMPLE cycle in which the gate output d is compared
// against the NAND of the pattern. Mismatches are logged per pattern in
// err_map and counted (saturating) in err_cnt. At the end of the sweep done
// rises and pass reports whether every pattern matched.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a sweep (honoured only in IDLE or DONE)
//   d        in   output of the gate under test
//   a,b,c    out  gate inputs; a is the pattern MSB, c the LSB
//   busy     out  high while a sweep is in progress
//   done     out  high once a sweep completes, until the next start
//   pass     out  high in DONE iff no pattern mismatched
//   err_cnt  out  number of mismatching patterns (saturating)
//   err_map  out  bit i set iff pattern i mismatched
//
// Parameters:
//   DWELL    cycles each pattern is driven before sampling (1..255)
//   CNT_W    dwell counter width; must hold DWELL-1
//   ERR_W    width of err_cnt
module nand3_stimulus_checker
    import nand3_stimulus_checker_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8,
    parameter int ERR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    d,
    output logic                    a,
    output logic                    b,
    output logic                    c,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ERR_W-1:0]        err_cnt,
    output logic [NUM_PATTERNS-1:0] err_map
);

    state_t          state;
    logic [2:0]      pattern;
    logic            timer_clear;
    logic            timer_enable;
    logic            dwell_expire;
    logic            mismatch;
    logic [ERR_W-1:0] err_cnt_next;

    // The timer only runs while a pattern is being driven; in every other
    // state it is held at zero so each DRIVE period starts from a fresh count.
    assign timer_enable = (state == DRIVE);
    assign timer_clear  = (state != DRIVE);

    dwell_timer #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (dwell_expire)
    );

    // The gate inputs come straight from the pattern register. The pattern
    // wraps back to 000 when the last one is sampled, so the register is
    // already 000 in IDLE and DONE without a separate output register.
    assign {a, b, c} = pattern;

    // Compare the gate response only in SAMPLE, and precompute the
    // saturating next error count so the final pass verdict can be taken
    // on the same edge that logs the last pattern's result.
    always_comb begin
        mismatch     = 1'b0;
        err_cnt_next = err_cnt;
        if (state == SAMPLE && d != expected_nand(pattern)) begin
            mismatch = 1'b1;
            if (err_cnt != '1) begin
                err_cnt_next = err_cnt + 1'b1;
            end
        end
    end

    // Sweep controller. All status outputs are registered here alongside
    // the state so they change cleanly on state transitions. start is only
    // looked at in IDLE and DONE, which makes a start during a sweep
    // harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pattern <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            err_map <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= DRIVE;
                        pattern <= 3'd0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        err_cnt <= '0;
                        err_map <= '0;
                    end
                end
                DRIVE: begin
                    if (dwell_expire) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_cnt <= err_cnt_next;
                    if (mismatch) begin
                        err_map[pattern] <= 1'b1;
                    end
                    pattern <= pattern + 3'd1;
                    if (pattern == LAST_PATTERN) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt_next == '0);
                    end else begin
                        state <= DRIVE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand3_stimulus_checker.sv
// Testbench for nand3_stimulus_checker.
//
// Two checkers are instantiated, one with DWELL=4 and one with DWELL=1.
// A behavioural gate model (correct NAND, stuck-at, AND, or NAND with a
// random per-pattern fault mask) answers on d during each sample cycle and
// with random noise on every other cycle. Expected pattern timing, error map,
// error count and pass are derived from the sweep rules with plain
// arithmetic.
module tb_nand3_stimulus_checker;

    localparam int ERR_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic start_r;
    logic d_r;
    logic sel;

    logic start4, start1;
    logic a4, b4, c4, busy4, done4, pass4;
    logic a1, b1, c1, busy1, done1, pass1;
    logic [ERR_W-1:0] err_cnt4, err_cnt1;
    logic [7:0]       err_map4, err_map1;

    logic [2:0]       obs_abc;
    logic             obs_busy, obs_done, obs_pass;
    logic [ERR_W-1:0] obs_err_cnt;
    logic [7:0]       obs_err_map;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Only the selected checker sees start; both see the same d.
    assign start4 = start_r & ~sel;
    assign start1 = start_r & sel;

    assign obs_abc     = sel ? {a1, b1, c1} : {a4, b4, c4};
    assign obs_busy    = sel ? busy1 : busy4;
    assign obs_done    = sel ? done1 : done4;
    assign obs_pass    = sel ? pass1 : pass4;
    assign obs_err_cnt = sel ? err_cnt1 : err_cnt4;
    assign obs_err_map = sel ? err_map1 : err_map4;

    nand3_stimulus_checker #(.DWELL(4), .CNT_W(8), .ERR_W(ERR_W)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start4),
        .d       (d_r),
        .a       (a4),
        .b       (b4),
        .c       (c4),
        .busy    (busy4),
        .done    (done4),
        .pass    (pass4),
        .err_cnt (err_cnt4),
        .err_map (err_map4)
    );

    nand3_stimulus_checker #(.DWELL(1), .CNT_W(8), .ERR_W(ERR_W)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
        .d       (d_r),
        .a       (a1),
        .b       (b1),
        .c       (c1),
        .busy    (busy1),
        .done    (done1),
        .pass    (pass1),
        .err_cnt (err_cnt1),
        .err_map (err_map1)
    );

    // Gate model: mode 0 NAND, 1 stuck-at-1, 2 stuck-at-0, 3 AND,
    // 4 NAND with the bits of flip inverting selected patterns.
    function automatic logic gate_out(input int mode, input logic [7:0] flip, input int p);
        logic nand_val;
        nand_val = (p != 7);
        case (mode)
            0:       return nand_val;
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return (p == 7);
            default: return nand_val ^ flip[p];
        endcase
    endfunction

    // Error map after the first npat patterns have been sampled.
    function automatic logic [7:0] expected_map(input int mode, input logic [7:0] flip, input int npat);
        logic [7:0] m;
        m = 8'h00;
        for (int p = 0; p < npat; p++) begin
            if (gate_out(mode, flip, p) != (p != 7)) begin
                m[p] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic int expected_cnt(input logic [7:0] m);
        int n;
        n = $countones(m);
        if (n > (1 << ERR_W) - 1) begin
            n = (1 << ERR_W) - 1;
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run one sweep on the checker with the given dwell. inject_at pulses
    // start mid-sweep on that cycle; stop_at returns early on that cycle
    // (before the sweep ends) so the caller can intervene.
    task automatic applyStimulus(input int dw, input int mode, input logic [7:0] flip,
                                 input int inject_at, input int stop_at);
        int total;
        int p;
        int n;
        logic [7:0] m;
        total = 8 * (dw + 1);
        sel = (dw == 1);
        @(negedge clk);
        start_r = 1'b1;
        d_r = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        start_r = 1'b0;
        for (int j = 1; j <= total; j++) begin
            p = (j - 1) / (dw + 1);
            checkOutput("pattern", 32'(obs_abc), p);
            checkOutput("busy_sweep", 32'(obs_busy), 1);
            checkOutput("done_sweep", 32'(obs_done), 0);
            checkOutput("pass_low", 32'(obs_pass), 0);
            if (j == 1) begin
                checkOutput("cleared_cnt", 32'(obs_err_cnt), 0);
                checkOutput("cleared_map", 32'(obs_err_map), 0);
            end
            if (j == stop_at) begin
                return;
            end
            if (j % (dw + 1) == 0) begin
                d_r = gate_out(mode, flip, p);
            end else begin
                d_r = ($urandom_range(0, 1) == 1);
            end
            start_r = (j == inject_at);
            @(negedge clk);
        end
        start_r = 1'b0;
        n = 0;
        while (obs_done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        m = expected_map(mode, flip, 8);
        checkOutput("done_latency", n, 0);
        checkOutput("done_high", 32'(obs_done), 1);
        checkOutput("busy_done", 32'(obs_busy), 0);
        checkOutput("abc_done", 32'(obs_abc), 0);
        checkOutput("err_map", 32'(obs_err_map), 32'(m));
        checkOutput("err_cnt", 32'(obs_err_cnt), expected_cnt(m));
        checkOutput("pass", 32'(obs_pass), (m == 8'h00) ? 1 : 0);
        repeat (2) begin
            d_r = ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        checkOutput("done_held", 32'(obs_done), 1);
        checkOutput("err_map_held", 32'(obs_err_map), 32'(m));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        logic [7:0] flip;
        rst_n   = 1'b0;
        start_r = 1'b0;
        d_r     = 1'b0;
        sel     = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_abc", 32'(obs_abc), 0);
        checkOutput("rst_busy", 32'(obs_busy), 0);
        checkOutput("rst_done", 32'(obs_done), 0);
        checkOutput("rst_pass", 32'(obs_pass), 0);
        checkOutput("rst_err_cnt", 32'(obs_err_cnt), 0);
        checkOutput("rst_err_map", 32'(obs_err_map), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_busy", 32'(obs_busy), 0);
        checkOutput("idle_abc", 32'(obs_abc), 0);

        $display("[TB] DWELL=4 fixed gate models");
        applyStimulus(4, 0, 8'h00, 0, 0);
        applyStimulus(4, 1, 8'h00, 0, 0);
        applyStimulus(4, 2, 8'h00, 0, 0);
        applyStimulus(4, 3, 8'h00, 0, 0);

        $display("[TB] DWELL=4 start during sweep, restart from DONE");
        applyStimulus(4, 0, 8'h00, 12, 0);
        applyStimulus(4, 0, 8'h00, 0, 0);

        $display("[TB] DWELL=4 random fault masks");
        for (int i = 0; i < 3; i++) begin
            flip = 8'($urandom);
            applyStimulus(4, 4, flip, 0, 0);
        end

        $display("[TB] DWELL=4 reset mid-sweep");
        applyStimulus(4, 2, 8'h00, 0, 17);
        checkOutput("mid_map", 32'(obs_err_map), 32'(expected_map(2, 8'h00, 3)));
        checkOutput("mid_cnt", 32'(obs_err_cnt), expected_cnt(expected_map(2, 8'h00, 3)));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_abc", 32'(obs_abc), 0);
        checkOutput("abort_busy", 32'(obs_busy), 0);
        checkOutput("abort_done", 32'(obs_done), 0);
        checkOutput("abort_err_cnt", 32'(obs_err_cnt), 0);
        checkOutput("abort_err_map", 32'(obs_err_map), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abort_no_restart", 32'(obs_busy), 0);
        checkOutput("abort_abc_idle", 32'(obs_abc), 0);
        applyStimulus(4, 0, 8'h00, 0, 0);

        $display("[TB] DWELL=1 sweeps");
        applyStimulus(1, 0, 8'h00, 0, 0);
        applyStimulus(1, 2, 8'h00, 0, 0);
        applyStimulus(1, 3, 8'h00, 5, 0);
        flip = 8'($urandom);
        applyStimulus(1, 4, flip, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
